inv_mix_columns_seq: RTL and testbench
======================================

# inv_mix_columns_seq

Iterative AES MixColumns / InvMixColumns engine for the 128/192/256-bit AES cores. It replaces per-coefficient byte lookup tables with an xtime-based GF(2^8) multiply datapath that serves both directions. One 128-bit state is processed per transaction, COLS_PER_CYCLE columns per clock, behind valid/ready handshakes on both sides. It sits between the ShiftRows/InvShiftRows stage and AddRoundKey in the round pipeline.

## Interface

- COLS_PER_CYCLE, default 1: columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a state is offered on in_state.
- in_ready  output  1  block can accept; high only in IDLE.
- in_state  input  128  AES state. Column c occupies bits [127-32c -: 32]. Byte r of the column is row r, with row 0 in the MSByte.
- in_inv  input  1  sampled at accept. 1 = InvMixColumns, 0 = MixColumns.
- out_valid  output  1  out_state holds the result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  transformed state, same byte layout as in_state.

## Operation

- GF(2^8) arithmetic uses the polynomial 0x11b. xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
- Products are built from xtime chains:
  - 2a = x(a), 3a = x(a)^a
  - 9a = x³(a)^a, 11a = x³(a)^x(a)^a
  - 13a = x³(a)^x²(a)^a, 14a = x³(a)^x²(a)^x(a)
- Forward transform, per column: b_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), with row indices mod 4.
- Inverse transform, per column: b_r = 14·a_r ^ 11·a_(r+1) ^ 13·a_(r+2) ^ 9·a_(r+3).
- The datapath has COLS_PER_CYCLE column units. The mode is muxed per unit, not duplicated per direction.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid=1, latch in_state into the working register, latch in_inv into the mode register, clear col_idx, and go to BUSY.
  - BUSY: columns col_idx .. col_idx+COLS_PER_CYCLE-1 are transformed and written back in place. col_idx advances by COLS_PER_CYCLE. When the last group (col_idx = 4-COLS_PER_CYCLE) has been written, go to DONE.
  - DONE: out_valid=1 and out_state = working register. On out_ready=1, go to IDLE.
- col_idx is a 2-bit counter. It wraps to 0 after the last group and is ignored outside BUSY.
- in_valid is ignored outside IDLE. in_state and in_inv are don't-care after accept; the working copy is used.
- out_state is stable while out_valid=1 and out_ready=0.
- out_state is not guaranteed meaningful outside DONE. It is driven from the working register.

## Timing

- Reset values: state=IDLE, in_ready=1, out_valid=0, out_state=128'h0, mode=0, col_idx=0.
- Reset is asynchronous. Asserting rst_n low mid-BUSY or mid-DONE immediately forces the reset values; the transaction is discarded.
- Accept happens at edge T. BUSY spans edges T+1 .. T+4/COLS_PER_CYCLE. out_valid is high after edge T+4/COLS_PER_CYCLE.
  - Latency is 4, 2 or 1 cycles for COLS_PER_CYCLE = 1, 2, 4.
- out_ready high in the first DONE cycle means out_valid drops after the next edge. in_ready rises on that same edge, so the next accept can happen one cycle later.
- Throughput, one state per 4/COLS_PER_CYCLE + 2 cycles:
  - 6 cycles at COLS_PER_CYCLE=1
  - 3 cycles at COLS_PER_CYCLE=4
- The critical path is one column unit: at most three xtime stages plus an XOR tree. There is no combinational path from in_* to out_*.

## Test plan

- Forward, for each COLS_PER_CYCLE value: in_inv=0, in_state=db135345_f20a225c_01010101_2d26314c -> out_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8. out_valid must rise exactly 4/COLS_PER_CYCLE cycles after accept.
- Inverse: in_inv=1, in_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8 -> out_state=db135345_f20a225c_01010101_2d26314c. Also in_state=c6c6c6c6_d4d4d4d5_... must round-trip, with d4d4d4d5 <-> d5d5d7d6.
- Coefficient spot-check, inverse mode: column 00000010 -> b = 9·10=90, 13·10=d0, 11·10=b0, 14·10=e0, i.e. column 90d0b0e0. Column 000000ff -> 9·ff=46 in row 0.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid stays 1, out_state stays stable, in_ready stays 0, and a pulsed in_valid is ignored. Then release out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: drop rst_n for 1 cycle during BUSY. Asynchronously get out_valid=0, out_state=0, in_ready=1. The next accepted state produces the correct result.
- Random: 1000 random states with random in_inv and random out_ready stalls, checked against a software model. Additionally, forward followed by inverse must give identity for every state.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES MixColumns / InvMixColumns engine: one 128-bit state per
// transaction, COLS_PER_CYCLE columns transformed per clock on a shared xtime datapath.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Each input byte contributes to four outputs with four coefficients; the
  // mode selects the coefficient set per byte so one xtime chain serves both directions.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  m0 [4];
    logic [7:0]  m1 [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  x1, x2, x3;
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x1    = xtime(a[r]);
      x2    = xtime(x1);
      x3    = xtime(x2);
      m0[r] = inv ? (x3 ^ x2 ^ x1)   : x1;
      m1[r] = inv ? (x3 ^ x1 ^ a[r]) : (x1 ^ a[r]);
      m2[r] = inv ? (x3 ^ x2 ^ a[r]) : a[r];
      m3[r] = inv ? (x3 ^ a[r])      : a[r];
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = m0[r] ^ m1[(r+1)%4] ^ m2[(r+2)%4] ^ m3[(r+3)%4];
    end
    return res;
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic         mode_q, mode_d;
  logic [127:0] work_q, work_d;

  logic [31:0]  cols      [4];
  logic [31:0]  nxt_cols  [4];
  logic [1:0]   unit_idx  [COLS_PER_CYCLE];
  logic [31:0]  unit_out  [COLS_PER_CYCLE];
  logic [127:0] work_mixed;

  for (genvar u = 0; u < COLS_PER_CYCLE; u++) begin : g_unit
    assign unit_idx[u] = col_idx_q + 2'(u);
    assign unit_out[u] = mix_col(cols[unit_idx[u]], mode_q);
  end

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path through the block can infer a latch.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols[c] = work_q[127-32*c -: 32];
    end
    for (int c = 0; c < 4; c++) begin
      nxt_cols[c] = cols[c];
    end
    for (int u = 0; u < COLS_PER_CYCLE; u++) begin
      nxt_cols[unit_idx[u]] = unit_out[u];
    end
    work_mixed = '0;
    for (int c = 0; c < 4; c++) begin
      work_mixed[127-32*c -: 32] = nxt_cols[c];
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    mode_d    = mode_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = in_state;
          mode_d    = in_inv;
          col_idx_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        work_d    = work_mixed;
        col_idx_d = col_idx_q + STEP;
        if (col_idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the working register is reset along with the control state because
  // out_state is driven straight from it and must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_idx_q <= 2'd0;
      mode_q    <= 1'b0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      mode_q    <= mode_d;
      work_q    <= work_d;
    end
  end

  assign out_state = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: three instances (1, 2, 4 columns
// per cycle) compared every output cycle against a GF(2^8) matrix reference model.
module tb_inv_mix_columns_seq;

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] RT_IN   = 128'hc6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] RT_OUT  = 128'hc6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] SPOT_IN = 128'h00000010_000000ff_00000000_00000000;
  localparam logic [127:0] SPOT_EX = 128'h90d0b0e0_4697a38d_00000000_00000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  // Generic shift-and-add GF(2^8) multiply modulo 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column: b_r = sum_j coef[j] * a_(r+j).
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(coef[j], s[127-32*c-8*((r+j)%4) -: 8]);
        end
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle an instance presents a result, it must equal the oldest expected state.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious out_valid dut%0d: got out_state %h with nothing pending", k, out_state[k]);
          end else begin
            check($sformatf("scoreboard dut%0d", k), out_state[k], exp_q[0]);
          end
        end
      end
    end
  end

  task automatic txn(input int k, input logic [127:0] s, input logic inv, input int hold,
                     output logic [127:0] r);
    int           n;
    int           waits;
    logic [127:0] held;
    r = '0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_state[k] = s;
    in_inv[k]   = inv;
    n = 0;
    while (in_ready[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready[k] !== 1'b1) begin
      check($sformatf("accept timeout dut%0d", k), {127'd0, in_ready[k]}, 128'd1);
      in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(model(s, inv));
    #1;
    in_valid[k] = 1'b0;
    in_state[k] = {$urandom, $urandom, $urandom, $urandom};
    in_inv[k]   = ~inv;
    n = 0;
    while (out_valid[k] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("latency dut%0d", k), 128'(n), 128'(4 >> k));
    if (out_valid[k] !== 1'b1) begin
      exp_q.delete();
      return;
    end
    held  = out_state[k];
    waits = (hold >= 0) ? hold : int'($urandom_range(0, 3));
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      out_ready[k] = 1'b0;
      in_valid[k]  = (i == waits / 2);
      in_state[k]  = {$urandom, $urandom, $urandom, $urandom};
      check($sformatf("stall out_valid dut%0d", k), {127'd0, out_valid[k]}, 128'd1);
      check($sformatf("stall in_ready dut%0d", k), {127'd0, in_ready[k]}, 128'd0);
      check($sformatf("stall stable dut%0d", k), out_state[k], held);
    end
    @(negedge clk);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    r = out_state[k];
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    out_ready[k] = 1'b0;
    check($sformatf("release out_valid dut%0d", k), {127'd0, out_valid[k]}, 128'd0);
    check($sformatf("release in_ready dut%0d", k), {127'd0, in_ready[k]}, 128'd1);
  endtask

  initial begin
    logic [127:0] r, r2, s;
    logic         inv;
    int           k;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_state[i]  = '0;
      in_inv[i]    = 1'b0;
      out_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset in_ready dut%0d", i), {127'd0, in_ready[i]}, 128'd1);
      check($sformatf("reset out_valid dut%0d", i), {127'd0, out_valid[i]}, 128'd0);
      check($sformatf("reset out_state dut%0d", i), out_state[i], 128'd0);
    end
    rst_n = 1'b1;

    check("model forward", model(FWD_IN, 1'b0), FWD_OUT);
    check("model inverse", model(FWD_OUT, 1'b1), FWD_IN);
    check("model roundtrip col", model(RT_IN, 1'b0), RT_OUT);
    check("model 9*ff", 128'(gmul(8'h09, 8'hff)), 128'h46);
    check("model spot", model(SPOT_IN, 1'b1), SPOT_EX);

    for (int i = 0; i < 3; i++) begin
      txn(i, FWD_IN, 1'b0, -1, r);
      check($sformatf("forward dut%0d", i), r, FWD_OUT);
      txn(i, FWD_OUT, 1'b1, -1, r);
      check($sformatf("inverse dut%0d", i), r, FWD_IN);
      txn(i, RT_IN, 1'b0, -1, r);
      check($sformatf("rt forward dut%0d", i), r, RT_OUT);
      txn(i, r, 1'b1, -1, r2);
      check($sformatf("rt inverse dut%0d", i), r2, RT_IN);
      txn(i, SPOT_IN, 1'b1, -1, r);
      check($sformatf("spot dut%0d", i), r, SPOT_EX);
    end

    txn(0, FWD_IN, 1'b0, 10, r);
    check("backpressure result", r, FWD_OUT);

    // Reset in the middle of a BUSY phase of the one-column instance.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = FWD_IN;
    in_inv[0]   = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(FWD_IN, 1'b0));
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async reset out_valid dut%0d", i), {127'd0, out_valid[i]}, 128'd0);
      check($sformatf("async reset out_state dut%0d", i), out_state[i], 128'd0);
      check($sformatf("async reset in_ready dut%0d", i), {127'd0, in_ready[i]}, 128'd1);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, FWD_OUT, 1'b1, -1, r);
    check("after reset", r, FWD_IN);

    for (int i = 0; i < 1000; i++) begin
      k   = i % 3;
      s   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      txn(k, s, inv, -1, r);
      txn(k, r, ~inv, -1, r2);
      check($sformatf("identity dut%0d", k), r2, s);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
